agc_mode_scheduler: RTL

//  Sequences the AGC loop (magnitude -> EMA -> error -> gain multiply): holds the

---
 rtl/agc_mode_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/agc_mode_scheduler.sv
// AGC loop mode scheduler: owns the coefficient/reference configuration,
// switches the core between fast (ACQUIRE) and slow (TRACK) loop constants,
// gates the sample strobe into the core and tracks loop lock.
// Optional feature macro: AGC_ACQ_TIMEOUT_EN (acquisition timeout -> HOLD).
module agc_mode_scheduler #(
    parameter int FILTERWIDTH = 13,
    parameter int RWIDTH      = 8,
    parameter int EWIDTH      = 27,
    parameter int CNTWIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic [15:0]              cfg_wdata,
    input  logic                     enable,
    input  logic                     freeze,
    input  logic                     s_valid,
    input  logic                     err_valid,
    input  logic signed [EWIDTH-1:0] err_data,
    output logic                     core_valid,
    output logic [FILTERWIDTH-1:0]   Filter_Coefficient,
    output logic [FILTERWIDTH-1:0]   Error_Coefficient,
    output logic [RWIDTH-1:0]        R_level,
    output logic                     locked,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [FILTERWIDTH-1:0] RST_FAST   = FILTERWIDTH'(16'h0800);
    localparam logic [FILTERWIDTH-1:0] RST_SLOW   = FILTERWIDTH'(16'h0100);
    localparam logic [RWIDTH-1:0]      RST_RLEVEL = RWIDTH'(16'h0040);
    localparam logic [15:0]            RST_THR    = 16'h0400;
    localparam logic [CNTWIDTH-1:0]    RST_LCNT   = CNTWIDTH'(16'd64);
    localparam logic [CNTWIDTH-1:0]    CNT_ZERO   = {CNTWIDTH{1'b0}};
    localparam logic [CNTWIDTH-1:0]    CNT_ONE    = {{(CNTWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTWIDTH-1:0]    CNT_MAX    = {CNTWIDTH{1'b1}};
    localparam logic [EWIDTH-1:0]      E_MAX      = {1'b0, {(EWIDTH-1){1'b1}}};
    localparam logic [EWIDTH-1:0]      E_MIN      = {1'b1, {(EWIDTH-1){1'b0}}};
    localparam logic [EWIDTH-1:0]      E_ONE      = {{(EWIDTH-1){1'b0}}, 1'b1};

    // Magnitude with saturation: the most negative value maps to the largest positive one.
    function automatic logic [EWIDTH-1:0] sat_abs(input logic [EWIDTH-1:0] v);
        logic [EWIDTH-1:0] r;
        if (v == E_MIN) begin
            r = E_MAX;
        end else if (v[EWIDTH-1]) begin
            r = ~v + E_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Multiply by four, clamped to the largest positive magnitude.
    function automatic logic [EWIDTH-1:0] sat_x4(input logic [EWIDTH-1:0] v);
        logic [EWIDTH+1:0] w;
        logic [EWIDTH-1:0] r;
        w = {v, 2'b00};
        if (w > {2'b00, E_MAX}) begin
            r = E_MAX;
        end else begin
            r = w[EWIDTH-1:0];
        end
        return r;
    endfunction

    // Saturating counter increment.
    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        logic [CNTWIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t state_q, state_d;
    logic                   locked_q, locked_d;
    logic [CNTWIDTH-1:0]    cnt_q, cnt_d;

    logic [FILTERWIDTH-1:0] sh_fast_filt_q, sh_fast_filt_d, act_fast_filt_q, act_fast_filt_d;
    logic [FILTERWIDTH-1:0] sh_fast_err_q, sh_fast_err_d, act_fast_err_q, act_fast_err_d;
    logic [FILTERWIDTH-1:0] sh_slow_filt_q, sh_slow_filt_d, act_slow_filt_q, act_slow_filt_d;
    logic [FILTERWIDTH-1:0] sh_slow_err_q, sh_slow_err_d, act_slow_err_q, act_slow_err_d;
    logic [RWIDTH-1:0]      sh_r_level_q, sh_r_level_d, act_r_level_q, act_r_level_d;
    logic [15:0]            sh_lock_thr_q, sh_lock_thr_d, act_lock_thr_q, act_lock_thr_d;
    logic [CNTWIDTH-1:0]    sh_lock_cnt_q, sh_lock_cnt_d, act_lock_cnt_q, act_lock_cnt_d;

    logic                   core_valid_q, core_valid_d;
    logic                   pending_q, pending_d;
    logic [FILTERWIDTH-1:0] filt_q, filt_d, errc_q, errc_d;
    logic [RWIDTH-1:0]      rlev_q, rlev_d;

    logic [EWIDTH-1:0]      abs_err_s, thr_s, thr4_s;
    logic [CNTWIDTH-1:0]    cnt_inc_s, lock_target_s;
    logic                   lock_hit_s, upd_s;

`ifdef AGC_ACQ_TIMEOUT_EN
    logic [CNTWIDTH-1:0]    sh_acq_to_q, sh_acq_to_d, act_acq_to_q, act_acq_to_d;
    logic [CNTWIDTH-1:0]    tcnt_q, tcnt_d, tcnt_inc_s;
    logic                   to_flag_q, to_flag_d, timeout_hit_s;

    assign tcnt_inc_s    = sat_inc(tcnt_q);
    assign timeout_hit_s = (act_acq_to_q != CNT_ZERO) && (tcnt_inc_s >= act_acq_to_q);
`endif

    assign abs_err_s     = sat_abs(err_data);
    assign thr_s         = {{(EWIDTH-16){1'b0}}, act_lock_thr_q};
    assign thr4_s        = sat_x4(thr_s);
    assign cnt_inc_s     = sat_inc(cnt_q);
    assign lock_target_s = (act_lock_cnt_q == CNT_ZERO) ? CNT_ONE : act_lock_cnt_q;
    assign lock_hit_s    = (abs_err_s <= thr_s) && (cnt_inc_s >= lock_target_s);
    // Active constants may only change between samples, never while one is in the core.
    assign upd_s         = !s_valid && !pending_q;

    // Config writes land in the shadow set; shadow copies to active between samples.
    always_comb begin
        sh_fast_filt_d = sh_fast_filt_q;
        sh_fast_err_d  = sh_fast_err_q;
        sh_slow_filt_d = sh_slow_filt_q;
        sh_slow_err_d  = sh_slow_err_q;
        sh_r_level_d   = sh_r_level_q;
        sh_lock_thr_d  = sh_lock_thr_q;
        sh_lock_cnt_d  = sh_lock_cnt_q;
`ifdef AGC_ACQ_TIMEOUT_EN
        sh_acq_to_d    = sh_acq_to_q;
`endif
        case ({cfg_we, cfg_addr})
            4'b1000: sh_fast_filt_d = cfg_wdata[FILTERWIDTH-1:0];
            4'b1001: sh_fast_err_d  = cfg_wdata[FILTERWIDTH-1:0];
            4'b1010: sh_slow_filt_d = cfg_wdata[FILTERWIDTH-1:0];
            4'b1011: sh_slow_err_d  = cfg_wdata[FILTERWIDTH-1:0];
            4'b1100: sh_r_level_d   = cfg_wdata[RWIDTH-1:0];
            4'b1101: sh_lock_thr_d  = cfg_wdata;
            4'b1110: sh_lock_cnt_d  = cfg_wdata[CNTWIDTH-1:0];
`ifdef AGC_ACQ_TIMEOUT_EN
            4'b1111: sh_acq_to_d    = cfg_wdata[CNTWIDTH-1:0];
`endif
            default: ;
        endcase
        if (upd_s) begin
            act_fast_filt_d = sh_fast_filt_q;
            act_fast_err_d  = sh_fast_err_q;
            act_slow_filt_d = sh_slow_filt_q;
            act_slow_err_d  = sh_slow_err_q;
            act_r_level_d   = sh_r_level_q;
            act_lock_thr_d  = sh_lock_thr_q;
            act_lock_cnt_d  = sh_lock_cnt_q;
        end else begin
            act_fast_filt_d = act_fast_filt_q;
            act_fast_err_d  = act_fast_err_q;
            act_slow_filt_d = act_slow_filt_q;
            act_slow_err_d  = act_slow_err_q;
            act_r_level_d   = act_r_level_q;
            act_lock_thr_d  = act_lock_thr_q;
            act_lock_cnt_d  = act_lock_cnt_q;
        end
`ifdef AGC_ACQ_TIMEOUT_EN
        if (upd_s) begin
            act_acq_to_d = sh_acq_to_q;
        end else begin
            act_acq_to_d = act_acq_to_q;
        end
`endif
    end

    // Shadow and active configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_fast_filt_q  <= RST_FAST;
            sh_fast_err_q   <= RST_FAST;
            sh_slow_filt_q  <= RST_SLOW;
            sh_slow_err_q   <= RST_SLOW;
            sh_r_level_q    <= RST_RLEVEL;
            sh_lock_thr_q   <= RST_THR;
            sh_lock_cnt_q   <= RST_LCNT;
            act_fast_filt_q <= RST_FAST;
            act_fast_err_q  <= RST_FAST;
            act_slow_filt_q <= RST_SLOW;
            act_slow_err_q  <= RST_SLOW;
            act_r_level_q   <= RST_RLEVEL;
            act_lock_thr_q  <= RST_THR;
            act_lock_cnt_q  <= RST_LCNT;
`ifdef AGC_ACQ_TIMEOUT_EN
            sh_acq_to_q     <= CNT_ZERO;
            act_acq_to_q    <= CNT_ZERO;
`endif
        end else begin
            sh_fast_filt_q  <= sh_fast_filt_d;
            sh_fast_err_q   <= sh_fast_err_d;
            sh_slow_filt_q  <= sh_slow_filt_d;
            sh_slow_err_q   <= sh_slow_err_d;
            sh_r_level_q    <= sh_r_level_d;
            sh_lock_thr_q   <= sh_lock_thr_d;
            sh_lock_cnt_q   <= sh_lock_cnt_d;
            act_fast_filt_q <= act_fast_filt_d;
            act_fast_err_q  <= act_fast_err_d;
            act_slow_filt_q <= act_slow_filt_d;
            act_slow_err_q  <= act_slow_err_d;
            act_r_level_q   <= act_r_level_d;
            act_lock_thr_q  <= act_lock_thr_d;
            act_lock_cnt_q  <= act_lock_cnt_d;
`ifdef AGC_ACQ_TIMEOUT_EN
            sh_acq_to_q     <= sh_acq_to_d;
            act_acq_to_q    <= act_acq_to_d;
`endif
        end
    end

    // FSM state register together with lock flag and lock counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
`ifdef AGC_ACQ_TIMEOUT_EN
            tcnt_q    <= CNT_ZERO;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
`ifdef AGC_ACQ_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

    // FSM next state: disable beats freeze, freeze beats normal sequencing.
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
`ifdef AGC_ACQ_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        to_flag_d = to_flag_q;
`endif
        if (!enable) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            cnt_d    = CNT_ZERO;
`ifdef AGC_ACQ_TIMEOUT_EN
            tcnt_d    = CNT_ZERO;
            to_flag_d = 1'b0;
`endif
        end else if (freeze) begin
            if ((state_q == ST_ACQ) || (state_q == ST_TRACK)) begin
                state_d = ST_HOLD;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ACQ;
                    locked_d = 1'b0;
                    cnt_d    = CNT_ZERO;
`ifdef AGC_ACQ_TIMEOUT_EN
                    tcnt_d   = CNT_ZERO;
`endif
                end
                ST_ACQ: begin
                    if (err_valid) begin
                        if (abs_err_s <= thr_s) begin
                            cnt_d = cnt_inc_s;
                        end else begin
                            cnt_d = CNT_ZERO;
                        end
`ifdef AGC_ACQ_TIMEOUT_EN
                        tcnt_d = tcnt_inc_s;
`endif
                        if (lock_hit_s) begin
                            state_d  = ST_TRACK;
                            locked_d = 1'b1;
                            cnt_d    = CNT_ZERO;
`ifdef AGC_ACQ_TIMEOUT_EN
                        end else if (timeout_hit_s) begin
                            state_d   = ST_HOLD;
                            to_flag_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_TRACK: begin
`ifdef AGC_ACQ_TIMEOUT_EN
                    tcnt_d = CNT_ZERO;
`endif
                    if (err_valid && (abs_err_s > thr4_s)) begin
                        state_d  = ST_ACQ;
                        locked_d = 1'b0;
                        cnt_d    = CNT_ZERO;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_HOLD: begin
`ifdef AGC_ACQ_TIMEOUT_EN
                    if (to_flag_q) begin
                        state_d = ST_HOLD;
                    end else if (locked_q) begin
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_ACQ;
                    end
`else
                    if (locked_q) begin
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_ACQ;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode: sample gating, in-flight tracking and coefficient selection.
    always_comb begin
        core_valid_d = s_valid && ((state_q == ST_ACQ) || (state_q == ST_TRACK));
        if (core_valid_d) begin
            pending_d = 1'b1;
        end else if (err_valid) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (state_q == ST_ACQ) begin
            filt_d = act_fast_filt_q;
            errc_d = act_fast_err_q;
        end else begin
            filt_d = act_slow_filt_q;
            errc_d = act_slow_err_q;
        end
        rlev_d = act_r_level_q;
    end

    // Registered outputs and pending-sample flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            filt_q       <= RST_SLOW;
            errc_q       <= RST_SLOW;
            rlev_q       <= RST_RLEVEL;
        end else begin
            core_valid_q <= core_valid_d;
            pending_q    <= pending_d;
            filt_q       <= filt_d;
            errc_q       <= errc_d;
            rlev_q       <= rlev_d;
        end
    end

    assign core_valid         = core_valid_q;
    assign Filter_Coefficient = filt_q;
    assign Error_Coefficient  = errc_q;
    assign R_level            = rlev_q;
    assign locked             = locked_q;
    assign state              = state_q;

endmodule
